// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response and memory-side signals of the unified memory arbiter.
// Ports (slave modport = arbiter view): if_* fetch port, d_* data port, mem_* memory strobes.
// Master modport is the environment view: requesters plus the synchronous-read memory.
interface mem_arbiter_if #(
  parameter int N        = 32,
  parameter int MEM_ADDR = 8
) ();
  logic                if_req;
  logic [MEM_ADDR-1:0] if_addr;
  logic [N-1:0]        if_rdata;
  logic                if_ready;
  logic                d_req;
  logic                d_we;
  logic [MEM_ADDR-1:0] d_addr;
  logic [N-1:0]        d_wdata;
  logic [N-1:0]        d_rdata;
  logic                d_ready;
  logic                mem_en;
  logic                mem_we;
  logic [MEM_ADDR-1:0] mem_addr;
  logic [N-1:0]        mem_wdata;
  logic [N-1:0]        mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between the fetch port and the data port.
// Latency: req sampled at edge T -> memory access cycle T..T+1, ready pulse cycle T+1..T+2.
// Backpressure: ready stays low while the other port owns the memory; req is held until ready.
// Ports: clk, rst (async, active high), bus (mem_arbiter_if.slave), conflict_cnt (saturating).
// Optional macro MEM_ARB_ROUND_ROBIN_EN: conflicts go to the port not granted last
// (default build: data always wins a conflict).
module mem_arbiter #(
  parameter int N        = 32,
  parameter int MEM_ADDR = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [2:0] {IDLE, F_ACC, D_ACC, F_RSP, D_RSP} state_t;

  state_t              state_q, state_d;
  logic [MEM_ADDR-1:0] addr_q, addr_d;
  logic                we_q, we_d;
  logic [N-1:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                decide;
  logic                elig_f, elig_d;
  logic                pick_d;
  logic                d_wins_tie;

  logic                mem_en, mem_we, if_ready, d_ready;
  logic [MEM_ADDR-1:0] mem_addr;
  logic [N-1:0]        mem_wdata, if_rdata, d_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_d_q: 1 = data granted most recently, 0 = fetch (reset value)
  logic last_d_q, last_d_d;
  assign d_wins_tie = ~last_d_q;
`else
  assign d_wins_tie = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_d  = last_d_q;
`endif
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    decide    = 1'b0;
    pick_d    = 1'b0;
    // A port being answered this cycle still has req high; it must not win again.
    elig_f    = bus.if_req && (state_q != F_RSP);
    elig_d    = bus.d_req  && (state_q != D_RSP);

    case (state_q)
      F_ACC: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = F_RSP;
      end
      D_ACC: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = D_RSP;
      end
      F_RSP: begin
        if_ready = 1'b1;
        if_rdata = bus.mem_rdata;
        decide   = 1'b1;
      end
      D_RSP: begin
        d_ready = 1'b1;
        d_rdata = we_q ? '0 : bus.mem_rdata;
        decide  = 1'b1;
      end
      default: decide = 1'b1;  // IDLE and unused encodings
    endcase

    // Grant from IDLE or either RSP state so accesses run back to back.
    if (decide) begin
      state_d = IDLE;
      if (elig_f && elig_d) begin
        pick_d = d_wins_tie;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        pick_d = elig_d;
      end
      if (elig_f || elig_d) begin
        state_d = pick_d ? D_ACC : F_ACC;
        addr_d  = pick_d ? bus.d_addr : bus.if_addr;
        we_d    = bus.d_we;
        wdata_d = bus.d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d = pick_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_ready  = if_ready;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_ready   = d_ready;
  assign bus.d_rdata   = d_rdata;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a synchronous-read memory model.
// Latency: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: requesters hold req until they observe their ready pulse.
module tb_mem_arbiter;
  localparam int N        = 32;
  localparam int MEM_ADDR = 8;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] conflict_cnt;

  mem_arbiter_if #(.N(N), .MEM_ADDR(MEM_ADDR)) bus ();

  mem_arbiter #(.N(N), .MEM_ADDR(MEM_ADDR), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h04) return 32'h0050_0093;
    return {a, a, a, a} ^ 32'h5A5A_0000;
  endfunction

  // Synchronous-read memory: read data appears the cycle after mem_en.
  logic [31:0]  mem [0:255];
  logic [255:0] written = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_en"},   32'(bus.mem_en),    0);
    chk({nm, "_mem_we"},   32'(bus.mem_we),    0);
    chk({nm, "_mem_addr"}, 32'(bus.mem_addr),  0);
    chk({nm, "_mem_wd"},   bus.mem_wdata,      0);
    chk({nm, "_if_ready"}, 32'(bus.if_ready),  0);
    chk({nm, "_if_rdata"}, bus.if_rdata,       0);
    chk({nm, "_d_ready"},  32'(bus.d_ready),   0);
    chk({nm, "_d_rdata"},  bus.d_rdata,        0);
    chk({nm, "_cnt"},      32'(conflict_cnt),  0);
  endtask

  // Hold the pending requests, dropping each one the cycle after its ready pulse.
  task automatic serve_both(input int bound);
    bit fd, dd;
    fd = !bus.if_req;
    dd = !bus.d_req;
    for (int c = 0; c < bound && !(fd && dd); c++) begin
      smp();
      if (bus.if_ready) fd = 1'b1;
      if (bus.d_ready)  dd = 1'b1;
      nxt();
      if (fd) bus.if_req = 1'b0;
      if (dd) bus.d_req  = 1'b0;
    end
    chk("serve_done", 32'({fd, dd}), 32'h3);
  endtask

  typedef struct {
    logic        iq;  logic [7:0] ia;
    logic        dq;  logic       dw;  logic [7:0] da;  logic [31:0] dwd;
    logic        en;  logic       we;  logic [7:0] ma;  logic [31:0] mwd;
    logic        ir;  logic [31:0] ird;
    logic        dr;  logic [31:0] drd;
    logic [3:0]  cnt;
  } vec_t;

  function automatic vec_t mkv(input int iq, input int ia, input int dq, input int dw,
                               input int da, input logic [31:0] dwd, input int en, input int we,
                               input int ma, input logic [31:0] mwd, input int ir,
                               input logic [31:0] ird, input int dr, input logic [31:0] drd,
                               input int cnt);
    vec_t r;
    r.iq = iq[0];  r.ia = ia[7:0];  r.dq = dq[0];  r.dw = dw[0];  r.da = da[7:0];
    r.dwd = dwd;   r.en = en[0];    r.we = we[0];  r.ma = ma[7:0]; r.mwd = mwd;
    r.ir = ir[0];  r.ird = ird;     r.dr = dr[0];  r.drd = drd;   r.cnt = cnt[3:0];
    return r;
  endfunction

  vec_t tbl [17];

  // Reference model state for the randomized phase.
  int          ph;        // 0 = free to grant, 1 = memory access, 2 = response
  bit          who_d, last_d, l_we;
  logic [7:0]  l_addr;
  logic [31:0] l_wd;
  int          cnt_m;
  logic [31:0] ref_mem [0:255];

  initial begin
    logic [31:0] db;
    bit          got [4];
    int          grants, f_n, d_n;
    bit          fr, dr, prev_en, ef, ed, pk;
    bit          e_en, e_we, e_ir, e_dr;
    logic [7:0]  e_ma;
    logic [31:0] e_ird, e_drd;

    db = 32'hDEAD_BEEF;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0;  bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    //           iq ia   dq dw da   dwd  en we ma   mwd  ir ird              dr drd              cnt
    tbl[0]  = mkv(1,'h04, 0,0,'h00, 0,   0,0,'h00, 0,   0,0,               0,0,               0);
    tbl[1]  = mkv(1,'h04, 0,0,'h00, 0,   1,0,'h04, 0,   0,0,               0,0,               0);
    tbl[2]  = mkv(1,'h04, 1,1,'h10, db,  0,0,'h00, 0,   1,32'h0050_0093,   0,0,               0);
    tbl[3]  = mkv(0,'h00, 1,1,'h10, db,  1,1,'h10, db,  0,0,               0,0,               0);
    tbl[4]  = mkv(0,'h00, 1,1,'h10, db,  0,0,'h00, 0,   0,0,               1,0,               0);
    tbl[5]  = mkv(0,'h00, 1,0,'h10, 0,   0,0,'h00, 0,   0,0,               0,0,               0);
    tbl[6]  = mkv(0,'h00, 1,0,'h10, 0,   1,0,'h10, 0,   0,0,               0,0,               0);
    tbl[7]  = mkv(0,'h00, 1,0,'h10, 0,   0,0,'h00, 0,   0,0,               1,db,              0);
    tbl[8]  = mkv(1,'h0C, 0,0,'h00, 0,   0,0,'h00, 0,   0,0,               0,0,               0);
    tbl[9]  = mkv(1,'h0C, 0,0,'h00, 0,   1,0,'h0C, 0,   0,0,               0,0,               0);
    tbl[10] = mkv(1,'h0C, 0,0,'h00, 0,   0,0,'h00, 0,   1,init_val(8'h0C), 0,0,               0);
    tbl[11] = mkv(1,'h08, 1,0,'h20, 0,   0,0,'h00, 0,   0,0,               0,0,               0);
    tbl[12] = mkv(1,'h08, 1,0,'h20, 0,   1,0,'h20, 0,   0,0,               0,0,               1);
    tbl[13] = mkv(1,'h08, 1,0,'h20, 0,   0,0,'h00, 0,   0,0,               1,init_val(8'h20), 1);
    tbl[14] = mkv(1,'h08, 0,0,'h00, 0,   1,0,'h08, 0,   0,0,               0,0,               1);
    tbl[15] = mkv(1,'h08, 0,0,'h00, 0,   0,0,'h00, 0,   1,init_val(8'h08), 0,0,               1);
    tbl[16] = mkv(0,'h00, 0,0,'h00, 0,   0,0,'h00, 0,   0,0,               0,0,               1);

    // Reset state.
    #2;
    chk_all_zero("reset");
    smp(); smp();
    rst = 1'b0;
    nxt();

    // Directed vectors: fetch, write, read-back, simultaneous requests.
    for (int i = 0; i < 17; i++) begin
      bus.if_req = tbl[i].iq; bus.if_addr = tbl[i].ia;
      bus.d_req = tbl[i].dq;  bus.d_we = tbl[i].dw; bus.d_addr = tbl[i].da; bus.d_wdata = tbl[i].dwd;
      smp();
      chk($sformatf("v%0d_mem_en", i),   32'(bus.mem_en),   32'(tbl[i].en));
      chk($sformatf("v%0d_mem_we", i),   32'(bus.mem_we),   32'(tbl[i].we));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].ma));
      if (tbl[i].we) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, tbl[i].mwd);
      chk($sformatf("v%0d_if_ready", i), 32'(bus.if_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d_if_rdata", i), bus.if_rdata,      tbl[i].ird);
      chk($sformatf("v%0d_d_ready", i),  32'(bus.d_ready),  32'(tbl[i].dr));
      chk($sformatf("v%0d_d_rdata", i),  bus.d_rdata,       tbl[i].drd);
      chk($sformatf("v%0d_cnt", i),      32'(conflict_cnt), 32'(tbl[i].cnt));
      nxt();
    end

    // Tie after a lone data grant: round robin gives fetch, fixed priority gives data.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h21;
    smp(); nxt();
    smp(); chk("tie_lone_d_addr", 32'(bus.mem_addr), 32'h21); nxt();
    smp(); chk("tie_lone_d_ready", 32'(bus.d_ready), 1); nxt();
    bus.d_addr = 8'h22; bus.if_req = 1'b1; bus.if_addr = 8'h0C;
    smp(); chk("tie_idle_en", 32'(bus.mem_en), 0); nxt();
    smp();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_winner_addr", 32'(bus.mem_addr), 32'h0C);
`else
    chk("tie_winner_addr", 32'(bus.mem_addr), 32'h22);
`endif
    chk("tie_cnt", 32'(conflict_cnt), 2);
    nxt();
    serve_both(20);

    // Reset asserted in the middle of a data write.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h30; bus.d_wdata = 32'hCAFE_F00D;
    smp(); nxt();
    smp();
    chk("rstmid_acc_en", 32'(bus.mem_en), 1);
    chk("rstmid_acc_we", 32'(bus.mem_we), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rstmid");
    nxt();
    bus.d_req = 1'b0;
    chk("rstmid_no_ready", 32'(bus.d_ready), 0);
    smp();
    rst = 1'b0;
    chk("rstmid_no_write", 32'(written[8'h30]), 0);
    nxt();
    bus.if_req = 1'b1; bus.if_addr = 8'h04;
    smp(); chk("post_rst_idle_en", 32'(bus.mem_en), 0); nxt();
    smp(); chk("post_rst_acc_addr", 32'(bus.mem_addr), 32'h04); nxt();
    bus.if_req = 1'b0;
    smp();
    chk("post_rst_if_ready", 32'(bus.if_ready), 1);
    chk("post_rst_if_rdata", bus.if_rdata, 32'h0050_0093);
    nxt();

    // Request withdrawn during its access still completes.
    bus.if_req = 1'b1; bus.if_addr = 8'h11;
    smp(); nxt();
    bus.if_req = 1'b0;
    smp(); chk("drop_acc_addr", 32'(bus.mem_addr), 32'h11); nxt();
    smp();
    chk("drop_if_ready", 32'(bus.if_ready), 1);
    chk("drop_if_rdata", bus.if_rdata, init_val(8'h11));
    nxt();
    smp(); chk("drop_idle_ready", 32'(bus.if_ready), 0); nxt();

    // Sustained contention, both ports re-presenting right after their ready.
    // The answered port is ineligible in its own response cycle, so grants alternate.
    f_n = 0; d_n = 0; grants = 0;
    bus.if_req = 1'b1; bus.if_addr = 8'h40;
    bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 8'h80;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      smp();
      if (bus.mem_en) begin
        got[grants] = bus.mem_addr[7];
        grants++;
      end
      fr = bus.if_ready; dr = bus.d_ready;
      nxt();
      if (fr) begin f_n++; bus.if_addr = 8'(8'h40 + f_n); end
      if (dr) begin d_n++; bus.d_addr  = 8'(8'h80 + d_n); end
    end
    chk("cont_grants", 32'(grants), 4);
    for (int g = 0; g < 4; g++)
      chk($sformatf("cont_grant%0d_is_d", g), 32'(got[g]), 32'((g % 2) == 0));
    serve_both(20);
    chk("cont_cnt", 32'(conflict_cnt), 1);

    // Drive the counter into saturation with repeated simultaneous requests.
    for (int k = 1; k <= 19; k++) begin
      bus.if_req = 1'b1; bus.if_addr = 8'(k);
      bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 8'(8'h40 + k);
      serve_both(20);
      if (k == 10) chk("sat_cnt_11", 32'(conflict_cnt), 11);
      if (k == 14) chk("sat_cnt_15", 32'(conflict_cnt), 15);
    end
    chk("sat_cnt_hold", 32'(conflict_cnt), 32'hF);

    // Randomized traffic against a transaction-level reference.
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    ref_mem[8'h10] = db;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    smp(); rst = 1'b1;
    smp(); rst = 1'b0;
    nxt();
    ph = 0; who_d = 1'b0; last_d = 1'b0; l_we = 1'b0; l_addr = '0; l_wd = '0; cnt_m = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      smp();
      e_en  = (ph == 1);
      e_we  = e_en && who_d && l_we;
      e_ma  = e_en ? l_addr : 8'h00;
      e_ir  = (ph == 2) && !who_d;
      e_dr  = (ph == 2) && who_d;
      e_ird = e_ir ? ref_mem[l_addr] : 32'h0;
      e_drd = (e_dr && !l_we) ? ref_mem[l_addr] : 32'h0;
      chk("rnd_mem_en",   32'(bus.mem_en),   32'(e_en));
      chk("rnd_mem_we",   32'(bus.mem_we),   32'(e_we));
      chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(e_ma));
      if (e_we) chk("rnd_mem_wdata", bus.mem_wdata, l_wd);
      chk("rnd_if_ready", 32'(bus.if_ready), 32'(e_ir));
      chk("rnd_if_rdata", bus.if_rdata,      e_ird);
      chk("rnd_d_ready",  32'(bus.d_ready),  32'(e_dr));
      chk("rnd_d_rdata",  bus.d_rdata,       e_drd);
      chk("rnd_cnt",      32'(conflict_cnt), 32'(cnt_m));
      chk("rnd_en_gap",   32'(prev_en & bus.mem_en), 0);
      prev_en = bus.mem_en;
      fr = bus.if_ready; dr = bus.d_ready;

      // Reference: a transaction occupies the memory one cycle, answers the next,
      // and the answering cycle may already start the next transaction.
      if (ph == 1) begin
        if (who_d && l_we) ref_mem[l_addr] = l_wd;
        ph = 2;
      end else begin
        ef = bus.if_req && !(ph == 2 && !who_d);
        ed = bus.d_req  && !(ph == 2 && who_d);
        if (ef && ed) begin
          cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          pk = !last_d;
`else
          pk = 1'b1;
`endif
        end else begin
          pk = ed;
        end
        if (ef || ed) begin
          who_d = pk; last_d = pk;
          l_addr = pk ? bus.d_addr : bus.if_addr;
          l_we = bus.d_we; l_wd = bus.d_wdata;
          ph = 1;
        end else begin
          ph = 0;
        end
      end

      nxt();
      if (bus.if_req ? fr : ($urandom_range(2, 0) == 0)) begin
        if (!bus.if_req || $urandom_range(1, 0) == 1) begin
          bus.if_req = 1'b1; bus.if_addr = 8'($urandom_range(31, 0));
        end else begin
          bus.if_req = 1'b0;
        end
      end
      if (bus.d_req ? dr : ($urandom_range(2, 0) == 0)) begin
        if (!bus.d_req || $urandom_range(1, 0) == 1) begin
          bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(1, 0));
          bus.d_addr = 8'($urandom_range(31, 0)); bus.d_wdata = $urandom();
        end else begin
          bus.d_req = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
